gate_op_arbiter: RTL and testbench

Round-robin arbiter that shares one registered bitwise logic unit (AND/OR/NAND/NOR/XOR/XNOR/NOT) between NREQ requesters.
- Each requester presents an opcode and two WIDTH-bit operands on a valid/ready channel.
- The block grants one requester per cycle and computes the result.
- The result is returned on a single response channel tagged with the requester ID.
- Sits between software-visible command sources and the gate datapath, so the gate logic is instantiated once.

---
 rtl/gate_op_pkg.sv | 17 +
 rtl/gate_op_unit.sv | 28 ++
 rtl/gate_op_arbiter.sv | 122 ++++++++++++
 tb/tb_gate_op_arbiter.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/gate_op_pkg.sv
// Shared opcode encoding for the gate-op arbiter and its bitwise logic unit.
package gate_op_pkg;

   localparam int OPW = 3;

   typedef enum logic [OPW-1:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_NAND = 3'd2,
      OP_NOR  = 3'd3,
      OP_XOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_NOTA = 3'd6,
      OP_NOTB = 3'd7
   } gate_op_e;

endpackage

// File: rtl/gate_op_unit.sv
// Purely combinational bitwise logic unit; result width equals operand width.
module gate_op_unit
   import gate_op_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  gate_op_e         op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] y
);

   always_comb begin
      y = '0;
      case (op)
         OP_AND:  y = a & b;
         OP_OR:   y = a | b;
         OP_NAND: y = ~(a & b);
         OP_NOR:  y = ~(a | b);
         OP_XOR:  y = a ^ b;
         OP_XNOR: y = ~(a ^ b);
         OP_NOTA: y = ~a;
         OP_NOTB: y = ~b;
         default: y = '0;
      endcase
   end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one registered gate_op_unit between NREQ requesters.
// Optional rsp_parity output is enabled by defining GATE_OP_ARB_PARITY_EN.
module gate_op_arbiter
   import gate_op_pkg::*;
#(
   parameter  int NREQ  = 4,
   parameter  int WIDTH = 8,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*OPW-1:0]   req_op,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [IDW-1:0]        rsp_id,
   output logic [WIDTH-1:0]      rsp_data
`ifdef GATE_OP_ARB_PARITY_EN
   ,
   output logic                  rsp_parity
`endif
);

   logic [IDW-1:0]   ptr_q, ptr_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]   rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

   logic [IDW-1:0]   grant_idx;
   logic             any_valid;
   logic             can_accept;
   logic             xfer;
   gate_op_e         op_sel;
   logic [WIDTH-1:0] a_sel, b_sel, y;

   // Grant = valid requester with the smallest circular distance from ptr.
   always_comb begin
      int best_d;
      int d;
      best_d    = NREQ;
      grant_idx = '0;
      op_sel    = OP_AND;
      a_sel     = '0;
      b_sel     = '0;
      for (int i = 0; i < NREQ; i++) begin
         d = (i + NREQ - int'(ptr_q)) % NREQ;
         if (req_valid[i] && (d < best_d)) begin
            best_d    = d;
            grant_idx = IDW'(i);
            op_sel    = gate_op_e'(req_op[OPW*i +: OPW]);
            a_sel     = req_a[WIDTH*i +: WIDTH];
            b_sel     = req_b[WIDTH*i +: WIDTH];
         end
      end
   end

   gate_op_unit #(.WIDTH(WIDTH)) u_unit (
      .op (op_sel),
      .a  (a_sel),
      .b  (b_sel),
      .y  (y)
   );

   always_comb begin
      any_valid   = |req_valid;
      can_accept  = !rsp_valid_q || rsp_ready;
      xfer        = can_accept && any_valid;
      req_ready   = '0;
      ptr_d       = ptr_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = rsp_valid_q && !rsp_ready;
      if (xfer) begin
         req_ready[grant_idx] = 1'b1;
         rsp_valid_d          = 1'b1;
         rsp_id_d             = grant_idx;
         rsp_data_d           = y;
         ptr_d                = (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         ptr_q       <= ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;

`ifdef GATE_OP_ARB_PARITY_EN
   logic parity_q, parity_d;

   // Parity follows the data register exactly, so it holds whenever data holds.
   always_comb begin
      parity_d = xfer ? ^y : parity_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign rsp_parity = parity_q;
`endif

endmodule

// File: tb/tb_gate_op_arbiter.sv
// Directed self-checking bench for gate_op_arbiter (NREQ=4, WIDTH=8).
module tb_gate_op_arbiter;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int IDW   = 2;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [NREQ*3-1:0]     req_op;
   logic [NREQ*WIDTH-1:0] req_a;
   logic [NREQ*WIDTH-1:0] req_b;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [IDW-1:0]        rsp_id;
   logic [WIDTH-1:0]      rsp_data;
`ifdef GATE_OP_ARB_PARITY_EN
   logic                  rsp_parity;
`endif

   int errors = 0;
   int checks = 0;

   gate_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data)
`ifdef GATE_OP_ARB_PARITY_EN
      ,
      .rsp_parity(rsp_parity)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
      req_op[3*i +: 3]     = op;
      req_a[WIDTH*i +: WIDTH] = a;
      req_b[WIDTH*i +: WIDTH] = b;
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_rsp(input string tag, input logic v, input logic [1:0] id, input logic [7:0] d);
      check({tag, ".valid"}, 32'(rsp_valid), 32'(v));
      check({tag, ".id"},    32'(rsp_id),    32'(id));
      check({tag, ".data"},  32'(rsp_data),  32'(d));
   endtask

   logic [7:0] sweep_exp [8];
   int         g;

   initial begin
      sweep_exp = '{8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h5A, 8'hF0};
      rst_n     = 1'b0;
      req_valid = '0;
      req_op    = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      #12;
      check_rsp("reset", 1'b0, 2'd0, 8'h00);
      check("reset.ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();

      // 1: single request from requester 2
      set_req(2, 3'd4, 8'hF0, 8'h3C);
      req_valid = 4'b0100;
      #1;
      check("t1.ready", 32'(req_ready), 32'b0100);
      tick();
      req_valid = '0;
      check_rsp("t1.rsp", 1'b1, 2'd2, 8'hCC);
      #1;
      check("t1.ready_idle", 32'(req_ready), 32'h0);
      tick();
      check_rsp("t1.drain", 1'b0, 2'd2, 8'hCC);

      // 2: all valid, pointer left at 3 so grants run 3,0,1,2,3
      for (int i = 0; i < NREQ; i++) set_req(i, 3'd0, 8'hFF, 8'(i * 8'h11));
      req_valid = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         g = (3 + k) % NREQ;
         #1;
         check($sformatf("t2.ready%0d", k), 32'(req_ready), 32'(1 << g));
         tick();
         check_rsp($sformatf("t2.rsp%0d", k), 1'b1, 2'(g), 8'(g * 8'h11));
      end
      req_valid = '0;
      tick();

      // 3: backpressure with id=1 data=55 pending, req 0 and 3 waiting
      set_req(1, 3'd1, 8'h55, 8'h00);
      req_valid = 4'b0010;
      tick();
      rsp_ready = 1'b0;
      set_req(0, 3'd2, 8'h0F, 8'hFF);
      set_req(3, 3'd4, 8'hF0, 8'h0F);
      req_valid = 4'b1001;
      for (int k = 0; k < 5; k++) begin
         #1;
         check($sformatf("t3.stall_ready%0d", k), 32'(req_ready), 32'h0);
         tick();
         check_rsp($sformatf("t3.hold%0d", k), 1'b1, 2'd1, 8'h55);
      end
      rsp_ready = 1'b1;
      #1;
      check("t3.ready3", 32'(req_ready), 32'b1000);
      tick();
      check_rsp("t3.rsp3", 1'b1, 2'd3, 8'hFF);
      check("t3.ready0", 32'(req_ready), 32'b0001);
      tick();
      req_valid = '0;
      check_rsp("t3.rsp0", 1'b1, 2'd0, 8'hF0);
      tick();
      check("t3.drain", 32'(rsp_valid), 32'h0);

      // 4: opcode sweep on requester 0, back to back
      req_valid = 4'b0001;
      for (int k = 0; k < 8; k++) begin
         set_req(0, 3'(k), 8'hA5, 8'h0F);
         tick();
         check_rsp($sformatf("t4.op%0d", k), 1'b1, 2'd0, sweep_exp[k]);
      end

      // 5: reset while a response is stalled
      req_valid = '0;
      rsp_ready = 1'b0;
      tick();
      check_rsp("t5.pending", 1'b1, 2'd0, 8'hF0);
      #2;
      rst_n = 1'b0;
      #1;
      check_rsp("t5.async", 1'b0, 2'd0, 8'h00);
      @(negedge clk);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      tick();
      check("t5.no_replay", 32'(rsp_valid), 32'h0);
      set_req(1, 3'd1, 8'h12, 8'h30);
      req_valid = 4'b0010;
      #1;
      check("t5.ready1", 32'(req_ready), 32'b0010);
      tick();
      req_valid = '0;
      check_rsp("t5.rsp", 1'b1, 2'd1, 8'h32);

`ifdef GATE_OP_ARB_PARITY_EN
      // 6: parity of registered result
      set_req(2, 3'd1, 8'h07, 8'h00);
      req_valid = 4'b0100;
      tick();
      check("t6.data07", 32'(rsp_data), 32'h07);
      check("t6.par07", 32'(rsp_parity), 32'h1);
      set_req(2, 3'd1, 8'h03, 8'h00);
      tick();
      req_valid = '0;
      check("t6.data03", 32'(rsp_data), 32'h03);
      check("t6.par03", 32'(rsp_parity), 32'h0);
`endif

      tick();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: bench did not reach its end");
      $fatal(1, "timeout");
   end

endmodule
